// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the byte-lane data memory.
// Holds RV32I load/store funct3 codes and the clear FSM state type.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR,
        RUN
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for RV32I loads and stores.
// Builds byte enables, shifted store data, extended load data and fault flags.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        write_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [4:0]  bit_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign bit_off  = {off_i, 3'b000};
    assign byte_sel = rword_i[bit_off +: 8];
    assign half_sel = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    assign wdata_o  = wdata_i << bit_off;

    // Halfwords need an even offset, words need offset zero.
    assign misalign_o = ((funct3_i[1:0] == 2'b01) && off_i[0])
                     || ((funct3_i[1:0] == 2'b10) && (off_i != 2'b00));

    // Decode access width into lane mask, load extension and legality.
    always_comb begin
        be_o      = 4'b0000;
        rdata_o   = 32'h0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << off_i;
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                be_o    = 4'b0011 << off_i;
                rdata_o = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                be_o    = 4'b1111;
                rdata_o = rword_i;
            end
            F3_BU: begin
                rdata_o   = {24'h0, byte_sel};
                illegal_o = write_i;
            end
            F3_HU: begin
                rdata_o   = {16'h0, half_sel};
                illegal_o = write_i;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressable data memory with one-cycle registered response.
// Zero-fills itself after reset before accepting any request.
module data_memory_bytelane
    import riscv_mem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 64,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    state_e        state_q;
    logic [AW-1:0] clear_ptr_q;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;
    logic [31:0]   rsp_rdata_d;

    logic [AW-1:0] idx;
    logic          oor;
    logic          accept;
    logic          err;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wdata_sh;
    logic [31:0]   rdata_ext;
    logic          misalign;
    logic          illegal;

    assign req_ready = (state_q == RUN);
    assign busy      = (state_q == CLEAR);
    assign idx       = req_addr[AW+1:2];
    assign oor       = |req_addr[31:AW+2];
    assign accept    = req_valid && req_ready;
    assign err       = oor || misalign || illegal;
    assign wr_en     = accept && req_write && !err;

    mem_lane_align u_align (
        .funct3_i   (req_funct3),
        .write_i    (req_write),
        .off_i      (req_addr[1:0]),
        .wdata_i    (req_wdata),
        .rword_i    (mem_q[idx]),
        .be_o       (be),
        .wdata_o    (wdata_sh),
        .rdata_o    (rdata_ext),
        .misalign_o (misalign),
        .illegal_o  (illegal)
    );

    // Load data only for a clean load; stores and faults return zero.
    assign rsp_rdata_d = (req_write || err) ? 32'h0 : rdata_ext;

    // Clear sequencer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && err;
            rsp_rdata_q <= accept ? rsp_rdata_d : 32'h0;
            if (state_q == CLEAR) begin
                clear_ptr_q <= clear_ptr_q + 1'b1;
                if (clear_ptr_q == AW'(DEPTH_WORDS - 1)) begin
                    state_q <= RUN;
                end
            end
        end
    end

    // Array writes: zero-fill while clearing, lane-masked stores otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clear_ptr_q] <= 32'h0;
            end else if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
